// File: rtl/lut_cfg_loader_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
package lut_cfg_loader_pkg;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  // Frame length: split bit plus two half-LUT memories of 2**inputs bits.
  function automatic int frame_bits(input int inputs);
    return 2 * (1 << inputs) + 1;
  endfunction

  // Counter width able to hold 0..fb inclusive.
  function automatic int cnt_w(input int fb);
    return $clog2(fb + 1);
  endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Serial-in/parallel-out frame register with bit counter and length check.
// frame_ok/frame_err describe the transfer happening this cycle (shift_en).
module lut_cfg_shifter
  import lut_cfg_loader_pkg::*;
#(
  parameter int FRAME_BITS = 33,
  parameter int CNT_W      = cnt_w(FRAME_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  bit_in,
  input  logic                  last_in,
  output logic [FRAME_BITS-1:0] data_o,
  output logic                  frame_ok,
  output logic                  frame_err
);

  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  at_len;

  // Shift new bit in at the LSB; the counter returns to zero whenever a frame
  // ends (good or bad) so the next transfer is always counted as bit 1.
  always_comb begin
    data_d    = data_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;
    at_len    = (cnt_inc == CNT_W'(FRAME_BITS));
    frame_ok  = shift_en && last_in && at_len;
    // last too early, or full length reached without last
    frame_err = shift_en && (last_in != at_len);
    if (shift_en) begin
      data_d = {data_q[FRAME_BITS-2:0], bit_in};
      cnt_d  = (last_in || at_len) ? '0 : cnt_inc;
    end
  end

  // Frame register and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/lut_cfg_loader.sv
// Configuration driver for a fracturable dual-LUT slice. Collects a serial
// frame, then either pulses cen with the whole frame (block mode) or walks
// every memory bit out through the single-bit write port (bit mode).
module lut_cfg_loader
  import lut_cfg_loader_pkg::*;
#(
  parameter  int INPUTS     = 4,
  localparam int MEM_SIZE   = 1 << INPUTS,
  localparam int FRAME_BITS = frame_bits(INPUTS)
) (
  input  logic                  cclk,
  input  logic                  crst_n,
  input  logic                  mode_bitwise,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_data,
  input  logic                  s_last,
  output logic                  cen,
  output logic [FRAME_BITS-1:0] config_out,
  output logic [INPUTS-1:0]     wr_addr,
  output logic                  data_in,
  output logic                  write_en,
  output logic                  write_lut_select,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = INPUTS + 1;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               s_ready_q, s_ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer;
  logic               frame_ok, frame_err;
  logic [2*MEM_SIZE-1:0] mem_bits;
  logic [IDX_W-1:0]   rd_idx;

  assign xfer = s_valid && s_ready_q;

  lut_cfg_shifter #(
    .FRAME_BITS (FRAME_BITS)
  ) u_shifter (
    .clk       (cclk),
    .rst_n     (crst_n),
    .shift_en  (xfer),
    .bit_in    (s_data),
    .last_in   (s_last),
    .data_o    (config_out),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  // Next-state logic: frame intake, commit/write sequencing, sticky error.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          mode_d  = mode_bitwise;
          state_d = ST_SHIFT;
          if (frame_err) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (frame_ok) begin
            // bit mode skips the commit cycle and starts writing at index 0
            state_d = mode_q ? ST_WRITE : ST_COMMIT;
            idx_d   = '0;
          end else if (frame_err) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // ready is a flop so it reads 0 straight out of reset
    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT);
  end

  // Control registers.
  always_ff @(posedge cclk) begin
    if (!crst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Output decode from registered state. Index MSB clear selects the upper
  // LUT (frame bits [2M-1:M]); flipping it maps the index onto the frame.
  always_comb begin
    mem_bits         = config_out[2*MEM_SIZE-1:0];
    rd_idx           = {~idx_q[INPUTS], idx_q[INPUTS-1:0]};
    cen              = (state_q == ST_COMMIT);
    write_en         = (state_q == ST_WRITE);
    wr_addr          = '0;
    data_in          = 1'b0;
    write_lut_select = 1'b0;
    if (write_en) begin
      wr_addr          = idx_q[INPUTS-1:0];
      data_in          = mem_bits[rd_idx];
      write_lut_select = ~idx_q[INPUTS];
    end
  end

  assign s_ready = s_ready_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
